// File: rtl/hazard_sched.sv
// Decode/execute interlock scheduler. It stalls fetch/decode for load-use hazards, multi-cycle
// MUL and data-memory wait states, flushes wrong-path fetches after BLX, and counts load-use
// stall cycles with a saturating counter.
module hazard_sched #(
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned OPCODE_W  = 5,
  parameter int unsigned REG_N     = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_N-1:0]    nREGA,
  input  logic [REG_N-1:0]    nREGB,
  input  logic                mem_ready,
  output logic                stall,
  output logic                flush,
  output logic [2:0]          sched_state,
  output logic [CNT_W-1:0]    ld_stall_cnt
);

  localparam logic [OPCODE_W-1:0] OpAdd  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OpMul  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OpAnd  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OpOrr  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OpXor  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OpStr  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OpCmp  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OpNot  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OpBlx  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OpPush = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OpAddi = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OpLsr  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OpLsl  = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OpAsr  = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OpMov  = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OpLdr  = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OpPop  = OPCODE_W'(16);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StMulBusy = 3'd1,
    StMemWait = 3'd2,
    StLdChk   = 3'd3,
    StFlush   = 3'd4
  } state_e;

  state_e               r_state;
  logic [3:0]           r_cnt;
  logic [REG_N-1:0]     r_ld_dst;
  logic                 r_is_load;
  logic [CNT_W-1:0]     r_ld_cnt;

  logic w_use_a;
  logic w_use_b;
  logic w_is_mem;
  logic w_is_ld;
  logic w_hit;

  // Decode which source fields the instruction in decode actually reads.
  always_comb begin
    w_use_a = 1'b0;
    w_use_b = 1'b0;
    case (opcode)
      OpAdd, OpMul, OpAnd, OpOrr, OpXor, OpStr, OpCmp: begin
        w_use_a = 1'b1;
        w_use_b = 1'b1;
      end
      OpNot, OpBlx, OpPush, OpAddi, OpLsr, OpLsl, OpAsr: w_use_a = 1'b1;
      OpMov, OpLdr: w_use_b = 1'b1;
      default: ;
    endcase
  end

  assign w_is_mem = (opcode == OpLdr) || (opcode == OpStr) || (opcode == OpPush) ||
                    (opcode == OpPop);
  assign w_is_ld  = (opcode == OpLdr) || (opcode == OpPop);
  assign w_hit    = (w_use_a && (nREGA == r_ld_dst)) || (w_use_b && (nREGB == r_ld_dst));

  // Interlock outputs derived from the registered state and the decode fields.
  always_comb begin
    stall = 1'b0;
    case (r_state)
      StMulBusy, StMemWait: stall = 1'b1;
      StLdChk:              stall = w_hit;
      default:              stall = 1'b0;
    endcase
  end

  assign flush        = (r_state == StFlush);
  assign sched_state  = r_state;
  assign ld_stall_cnt = r_ld_cnt;

  // Scheduler FSM with its shared countdown, load tracking and stall counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_ld_dst  <= '0;
      r_is_load <= 1'b0;
      r_ld_cnt  <= '0;
    end else begin
      case (r_state)
        StIdle, StLdChk: begin
          if (r_state == StLdChk) r_is_load <= 1'b0;
          if ((r_state == StLdChk) && w_hit) begin
            // One bubble; the dependent instruction issues from IDLE without a recheck.
            r_state <= StIdle;
            if (r_ld_cnt != '1) r_ld_cnt <= r_ld_cnt + 1'b1;
          end else if (opcode == OpBlx) begin
            r_state <= StFlush;
            r_cnt   <= 4'(FLUSH_CYC);
          end else if (w_is_mem) begin
            r_state   <= StMemWait;
            r_is_load <= w_is_ld;
            if (w_is_ld) r_ld_dst <= nREGA;
          end else if ((opcode == OpMul) && (MUL_LAT > 1)) begin
            r_state <= StMulBusy;
            r_cnt   <= 4'(MUL_LAT - 1);
          end else begin
            r_state <= StIdle;
          end
        end
        StMulBusy: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= StIdle;
        end
        StMemWait: begin
          if (mem_ready) r_state <= r_is_load ? StLdChk : StIdle;
        end
        StFlush: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed scenarios then randomized decode traffic, checked against a
// cycle-budget reference model through a scoreboard queue.
module tb_hazard_sched;

  localparam int MulLat   = 3;
  localparam int FlushCyc = 2;

  localparam int OpAdd = 0, OpMul = 1, OpAnd = 2, OpOrr = 3, OpXor = 4, OpStr = 5, OpCmp = 6;
  localparam int OpNot = 7, OpBlx = 8, OpPush = 9, OpAddi = 10, OpLsr = 11, OpLsl = 12;
  localparam int OpAsr = 13, OpMov = 14, OpLdr = 15, OpPop = 16, OpNop = 20;

  logic        clk;
  logic        reset_n;
  logic [4:0]  opcode;
  logic [3:0]  nREGA;
  logic [3:0]  nREGB;
  logic        mem_ready;
  logic        stall, flush, stall_s, flush_s;
  logic [2:0]  sched_state, sched_state_s;
  logic [15:0] ld_stall_cnt;
  logic [1:0]  ld_stall_cnt_s;

  hazard_sched #(.MUL_LAT(MulLat), .FLUSH_CYC(FlushCyc), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .nREGA(nREGA), .nREGB(nREGB),
    .mem_ready(mem_ready), .stall(stall), .flush(flush), .sched_state(sched_state),
    .ld_stall_cnt(ld_stall_cnt)
  );

  hazard_sched #(.MUL_LAT(MulLat), .FLUSH_CYC(FlushCyc), .CNT_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .nREGA(nREGA), .nREGB(nREGB),
    .mem_ready(mem_ready), .stall(stall_s), .flush(flush_s), .sched_state(sched_state_s),
    .ld_stall_cnt(ld_stall_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit stall;
    bit flush;
    int st;
    int cnt;
    int cnt_s;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: remaining stall/flush cycle budgets rather than an explicit state machine.
  int flush_left, mul_left, n_ld;
  bit mem_pending, pend_load, chk_pending;
  int ld_dst;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads_reg(input int op, input int a, input int b, input int r);
    bit ua, ub;
    ua = op inside {OpAdd, OpMul, OpAnd, OpOrr, OpXor, OpStr, OpCmp,
                    OpNot, OpBlx, OpPush, OpAddi, OpLsr, OpLsl, OpAsr};
    ub = op inside {OpAdd, OpMul, OpAnd, OpOrr, OpXor, OpStr, OpCmp, OpMov, OpLdr};
    return (ua && a == r) || (ub && b == r);
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_reset();
    flush_left = 0; mul_left = 0; n_ld = 0;
    mem_pending = 0; pend_load = 0; chk_pending = 0; ld_dst = 0;
  endtask

  task automatic model_issue(input int op, input int a);
    if (op == OpBlx) flush_left = FlushCyc;
    else if (op inside {OpLdr, OpStr, OpPush, OpPop}) begin
      mem_pending = 1;
      pend_load   = op inside {OpLdr, OpPop};
      if (pend_load) ld_dst = a;
    end else if (op == OpMul && MulLat > 1) mul_left = MulLat - 1;
  endtask

  task automatic model_step(input int op, input int a, input int b, input bit mr,
                            output exp_t e);
    e.stall = 0; e.flush = 0;
    e.cnt   = sat(n_ld, 16);
    e.cnt_s = sat(n_ld, 2);
    if (flush_left > 0) begin
      e.st = 4; e.flush = 1; flush_left--;
    end else if (mul_left > 0) begin
      e.st = 1; e.stall = 1; mul_left--;
    end else if (mem_pending) begin
      e.st = 2; e.stall = 1;
      if (mr) begin mem_pending = 0; chk_pending = pend_load; end
    end else if (chk_pending) begin
      e.st = 3; chk_pending = 0;
      if (reads_reg(op, a, b, ld_dst)) begin e.stall = 1; n_ld++; end
      else model_issue(op, a);
    end else begin
      e.st = 0; model_issue(op, a);
    end
  endtask

  // One decode cycle: drive away from the edge, predict outputs, queue the prediction.
  task automatic cycle(input int op, input int a, input int b, input bit mr, input bit rst);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = 5'(op); nREGA = 4'(a); nREGB = 4'(b); mem_ready = mr;
    if (rst) begin
      reset_n = 1'b0;
      model_reset();
      e = '{stall: 0, flush: 0, st: 0, cnt: 0, cnt_s: 0};
      sb.push_back(e);
      #1;
      chk("rst_stall", int'(stall), 0);
      chk("rst_flush", int'(flush), 0);
      chk("rst_state", int'(sched_state), 0);
      chk("rst_cnt", int'(ld_stall_cnt), 0);
      chk("rst_cnt_s", int'(ld_stall_cnt_s), 0);
    end else begin
      reset_n = 1'b1;
      model_step(op, a, b, mr, e);
      sb.push_back(e);
    end
  endtask

  // Monitor: compare every presented cycle against the oldest queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall", int'(stall), int'(e.stall));
        chk("flush", int'(flush), int'(e.flush));
        chk("sched_state", int'(sched_state), e.st);
        chk("ld_stall_cnt", int'(ld_stall_cnt), e.cnt);
        chk("ld_stall_cnt_sat", int'(ld_stall_cnt_s), e.cnt_s);
        chk("stall_flush_excl", int'(stall & flush), 0);
        chk("sat_dut_state", int'(sched_state_s), e.st);
      end
    end
  end

  initial begin
    int op;
    reset_n = 1'b0; opcode = '0; nREGA = '0; nREGB = '0; mem_ready = 1'b0;
    model_reset();
    cycle(OpNop, 0, 0, 0, 1);
    cycle(OpNop, 0, 0, 0, 1);
    // MUL then ADD held in decode through the MUL stall.
    cycle(OpMul, 1, 2, 0, 0);
    repeat (3) cycle(OpAdd, 3, 4, 0, 0);
    cycle(OpNop, 0, 0, 0, 0);
    // LDR r5 with a dependent ADD r7,r5; memory completes two cycles after issue.
    cycle(OpLdr, 5, 6, 0, 0);
    cycle(OpAdd, 7, 5, 0, 0);
    cycle(OpAdd, 7, 5, 1, 0);
    repeat (2) cycle(OpAdd, 7, 5, 0, 0);
    cycle(OpNop, 0, 0, 0, 0);
    // LDR r5 with an independent ADD.
    cycle(OpLdr, 5, 6, 0, 0);
    cycle(OpAdd, 7, 8, 1, 0);
    cycle(OpAdd, 7, 8, 0, 0);
    cycle(OpNop, 0, 0, 0, 0);
    // POP r5 then MOV r2,r5.
    cycle(OpPop, 5, 0, 0, 0);
    cycle(OpMov, 2, 5, 1, 0);
    repeat (2) cycle(OpMov, 2, 5, 0, 0);
    cycle(OpNop, 0, 0, 0, 0);
    // BLX with MUL presented during the flush window.
    cycle(OpBlx, 3, 0, 1, 0);
    repeat (2) cycle(OpMul, 1, 1, 1, 0);
    repeat (3) cycle(OpNop, 0, 0, 0, 0);
    // Reset asserted while a store is waiting on memory.
    cycle(OpStr, 1, 2, 0, 0);
    cycle(OpNop, 0, 0, 0, 0);
    cycle(OpNop, 0, 0, 0, 1);
    cycle(OpNop, 0, 0, 0, 0);
    // Five load-use stalls push the 2-bit counter into saturation.
    repeat (5) begin
      cycle(OpLdr, 5, 0, 0, 0);
      cycle(OpNop, 0, 0, 1, 0);
      repeat (2) cycle(OpAdd, 5, 5, 0, 0);
    end
    cycle(OpNop, 0, 0, 0, 0);
    // Randomized traffic with a small register space so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: op = OpLdr;
          1: op = OpPop;
          2: op = OpMul;
          default: op = OpBlx;
        endcase
      end else begin
        op = int'($urandom_range(0, 23));
      end
      cycle(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 299) == 0));
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
